tcdm_lane_arbiter: RTL and testbench



---
 rtl/tcdm_lane_arbiter.sv | 171 +++++++++++++++++
 tb/tb_tcdm_lane_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_lane_arbiter.sv
// Per-lane two-requester TCDM arbiter with an in-order owner FIFO that steers responses back.
// Optional build macro TCDM_ARB_FIXED_PRIO_EN: A always wins contention (default is round-robin).
module tcdm_lane_arbiter #(
    parameter int NB_LANES   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_OUTST  = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NB_LANES-1:0]                   a_req_i,
    input  logic [NB_LANES-1:0][ADDR_WIDTH-1:0]   a_add_i,
    input  logic [NB_LANES-1:0]                   a_wen_i,
    input  logic [NB_LANES-1:0][DATA_WIDTH-1:0]   a_wdata_i,
    input  logic [NB_LANES-1:0][DATA_WIDTH/8-1:0] a_be_i,
    output logic [NB_LANES-1:0]                   a_gnt_o,
    output logic [NB_LANES-1:0]                   a_r_valid_o,
    output logic [NB_LANES-1:0][DATA_WIDTH-1:0]   a_r_rdata_o,
    input  logic [NB_LANES-1:0]                   b_req_i,
    input  logic [NB_LANES-1:0][ADDR_WIDTH-1:0]   b_add_i,
    input  logic [NB_LANES-1:0]                   b_wen_i,
    input  logic [NB_LANES-1:0][DATA_WIDTH-1:0]   b_wdata_i,
    input  logic [NB_LANES-1:0][DATA_WIDTH/8-1:0] b_be_i,
    output logic [NB_LANES-1:0]                   b_gnt_o,
    output logic [NB_LANES-1:0]                   b_r_valid_o,
    output logic [NB_LANES-1:0][DATA_WIDTH-1:0]   b_r_rdata_o,
    output logic [NB_LANES-1:0]                   tcdm_req_o,
    output logic [NB_LANES-1:0][ADDR_WIDTH-1:0]   tcdm_add_o,
    output logic [NB_LANES-1:0]                   tcdm_wen_o,
    output logic [NB_LANES-1:0][DATA_WIDTH-1:0]   tcdm_wdata_o,
    output logic [NB_LANES-1:0][DATA_WIDTH/8-1:0] tcdm_be_o,
    input  logic [NB_LANES-1:0]                   tcdm_gnt_i,
    input  logic [NB_LANES-1:0]                   tcdm_r_valid_i,
    input  logic [NB_LANES-1:0][DATA_WIDTH-1:0]   tcdm_r_rdata_i,
    output logic                                  busy_o,
    output logic                                  err_o
);

    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTST - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTST);

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        if (ptr == LAST_PTR) begin
            return {PW{1'b0}};
        end else begin
            return ptr + PW'(1);
        end
    endfunction

    logic [NB_LANES-1:0] w_nonempty;
    logic [NB_LANES-1:0] w_orphan;
    logic                r_err;

    for (genvar l = 0; l < NB_LANES; l++) begin : g_lane
        logic [MAX_OUTST-1:0] r_own;
        logic [PW-1:0]        r_head;
        logic [PW-1:0]        r_tail;
        logic [CW-1:0]        r_cnt;
        logic                 w_empty;
        logic                 w_full;
        logic                 w_can_issue;
        logic                 w_sel_b;
        logic                 w_req;
        logic                 w_push;
        logic                 w_pop;

        assign w_empty     = (r_cnt == {CW{1'b0}});
        assign w_full      = (r_cnt == FULL_CNT);
        // A full FIFO may still accept a grant when its head retires in the same cycle.
        assign w_can_issue = ~w_full | tcdm_r_valid_i[l];
        assign w_pop       = tcdm_r_valid_i[l] & ~w_empty & ~rst_i;
        assign w_orphan[l] = tcdm_r_valid_i[l] & w_empty & ~rst_i;
        assign w_nonempty[l] = ~w_empty;

`ifdef TCDM_ARB_FIXED_PRIO_EN
        assign w_sel_b = b_req_i[l] & ~a_req_i[l];
`else
        logic r_prio;

        // Round-robin choice: prio breaks the tie only when both request.
        always_comb begin
            if (a_req_i[l] & b_req_i[l]) begin
                w_sel_b = r_prio;
            end else begin
                w_sel_b = b_req_i[l];
            end
        end

        // Priority pointer moves to the loser on every handshake.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_prio <= 1'b0;
            end else if (w_push) begin
                r_prio <= ~w_sel_b;
            end else begin
                r_prio <= r_prio;
            end
        end
`endif

        assign w_req = (a_req_i[l] | b_req_i[l]) & w_can_issue & ~rst_i;
        assign w_push = w_req & tcdm_gnt_i[l];

        // Forward the selected requester's payload downstream.
        always_comb begin
            tcdm_req_o[l] = w_req;
            if (w_sel_b) begin
                tcdm_add_o[l]   = b_add_i[l];
                tcdm_wen_o[l]   = b_wen_i[l];
                tcdm_wdata_o[l] = b_wdata_i[l];
                tcdm_be_o[l]    = b_be_i[l];
            end else begin
                tcdm_add_o[l]   = a_add_i[l];
                tcdm_wen_o[l]   = a_wen_i[l];
                tcdm_wdata_o[l] = a_wdata_i[l];
                tcdm_be_o[l]    = a_be_i[l];
            end
        end

        assign a_gnt_o[l]     = w_push & ~w_sel_b;
        assign b_gnt_o[l]     = w_push & w_sel_b;
        assign a_r_valid_o[l] = w_pop & ~r_own[r_head];
        assign b_r_valid_o[l] = w_pop & r_own[r_head];
        assign a_r_rdata_o[l] = tcdm_r_rdata_i[l];
        assign b_r_rdata_o[l] = tcdm_r_rdata_i[l];

        // Owner FIFO: 0 = A, 1 = B; push on handshake, pop on response.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_own  <= {MAX_OUTST{1'b0}};
                r_head <= {PW{1'b0}};
                r_tail <= {PW{1'b0}};
                r_cnt  <= {CW{1'b0}};
            end else begin
                if (w_push) begin
                    r_own[r_tail] <= w_sel_b;
                    r_tail        <= next_ptr(r_tail);
                end else begin
                    r_tail <= r_tail;
                end
                if (w_pop) begin
                    r_head <= next_ptr(r_head);
                end else begin
                    r_head <= r_head;
                end
                case ({w_push, w_pop})
                    2'b10:   r_cnt <= r_cnt + CW'(1);
                    2'b01:   r_cnt <= r_cnt - CW'(1);
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

    // Sticky flag for responses that arrive with no outstanding owner.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (|w_orphan) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    assign err_o  = r_err;
    assign busy_o = |w_nonempty;

endmodule

// File: tb/tb_tcdm_lane_arbiter.sv
// Directed self-checking bench for tcdm_lane_arbiter (4 lanes, MAX_OUTST = 2).
module tb_tcdm_lane_arbiter;
    localparam int NL = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk_i = 1'b0;
    logic rst_i;
    logic [NL-1:0]           a_req_i, b_req_i, a_wen_i, b_wen_i;
    logic [NL-1:0][AW-1:0]   a_add_i, b_add_i;
    logic [NL-1:0][DW-1:0]   a_wdata_i, b_wdata_i;
    logic [NL-1:0][DW/8-1:0] a_be_i, b_be_i;
    logic [NL-1:0]           a_gnt_o, b_gnt_o, a_r_valid_o, b_r_valid_o;
    logic [NL-1:0][DW-1:0]   a_r_rdata_o, b_r_rdata_o;
    logic [NL-1:0]           tcdm_req_o, tcdm_wen_o, tcdm_gnt_i, tcdm_r_valid_i;
    logic [NL-1:0][AW-1:0]   tcdm_add_o;
    logic [NL-1:0][DW-1:0]   tcdm_wdata_o, tcdm_r_rdata_i;
    logic [NL-1:0][DW/8-1:0] tcdm_be_o;
    logic busy_o, err_o;

    int checks = 0;
    int failures = 0;

    tcdm_lane_arbiter #(.NB_LANES(NL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTST(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .a_req_i(a_req_i), .a_add_i(a_add_i), .a_wen_i(a_wen_i), .a_wdata_i(a_wdata_i), .a_be_i(a_be_i),
        .a_gnt_o(a_gnt_o), .a_r_valid_o(a_r_valid_o), .a_r_rdata_o(a_r_rdata_o),
        .b_req_i(b_req_i), .b_add_i(b_add_i), .b_wen_i(b_wen_i), .b_wdata_i(b_wdata_i), .b_be_i(b_be_i),
        .b_gnt_o(b_gnt_o), .b_r_valid_o(b_r_valid_o), .b_r_rdata_o(b_r_rdata_o),
        .tcdm_req_o(tcdm_req_o), .tcdm_add_o(tcdm_add_o), .tcdm_wen_o(tcdm_wen_o),
        .tcdm_wdata_o(tcdm_wdata_o), .tcdm_be_o(tcdm_be_o),
        .tcdm_gnt_i(tcdm_gnt_i), .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_rdata_i(tcdm_r_rdata_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change at negedge; combinational outputs are checked 1 time unit later.
    task automatic next_cyc();
        @(negedge clk_i);
    endtask

    task automatic clear_inputs();
        a_req_i = '0; b_req_i = '0; a_wen_i = '1; b_wen_i = '1;
        a_add_i = '0; b_add_i = '0; a_wdata_i = '0; b_wdata_i = '0;
        a_be_i = '1; b_be_i = '1;
        tcdm_gnt_i = '0; tcdm_r_valid_i = '0; tcdm_r_rdata_i = '0;
    endtask

    task automatic do_reset();
        next_cyc();
        clear_inputs();
        rst_i = 1'b1;
        a_req_i = 4'b1111; b_req_i = 4'b1111; tcdm_gnt_i = 4'b1111; tcdm_r_valid_i = 4'b1111;
        #1;
        chk("rst_tcdm_req", 64'(tcdm_req_o), 64'h0);
        chk("rst_gnt", 64'({a_gnt_o, b_gnt_o}), 64'h0);
        chk("rst_rvalid", 64'({a_r_valid_o, b_r_valid_o}), 64'h0);
        next_cyc();
        next_cyc();
        clear_inputs();
        rst_i = 1'b0;
        #1;
        chk("rst_busy", 64'(busy_o), 64'h0);
        chk("rst_err", 64'(err_o), 64'h0);
    endtask

    initial begin
        rst_i = 1'b1;
        clear_inputs();
        do_reset();

`ifndef TCDM_ARB_FIXED_PRIO_EN
        // Lane 0: A and B read continuously; grants alternate A,B,A,B and responses follow one cycle later.
        for (int i = 0; i < 5; i++) begin
            next_cyc();
            a_req_i[0] = (i < 4); b_req_i[0] = (i < 4);
            a_add_i[0] = 32'h0000_0010; b_add_i[0] = 32'h0000_0020;
            tcdm_gnt_i[0] = 1'b1;
            tcdm_r_valid_i[0] = (i >= 1);
            tcdm_r_rdata_i[0] = 32'hC0DE_0000 + 32'(i);
            #1;
            chk("rr_a_gnt", 64'(a_gnt_o[0]), 64'((i < 4) && (i % 2 == 0)));
            chk("rr_b_gnt", 64'(b_gnt_o[0]), 64'((i < 4) && (i % 2 == 1)));
            if (i < 4) chk("rr_add", 64'(tcdm_add_o[0]), (i % 2 == 0) ? 64'h10 : 64'h20);
            chk("rr_a_rvalid", 64'(a_r_valid_o[0]), 64'((i >= 1) && ((i - 1) % 2 == 0)));
            chk("rr_b_rvalid", 64'(b_r_valid_o[0]), 64'((i >= 1) && ((i - 1) % 2 == 1)));
            chk("rr_a_rdata", 64'(a_r_rdata_o[0]), 64'(32'hC0DE_0000 + 32'(i)));
            chk("rr_b_rdata", 64'(b_r_rdata_o[0]), 64'(32'hC0DE_0000 + 32'(i)));
        end
        next_cyc();
        clear_inputs();
        #1;
        chk("rr_idle_busy", 64'(busy_o), 64'h0);

        // Lane 2: single A write, response the next cycle.
        a_req_i[2] = 1'b1; a_wen_i[2] = 1'b0; a_add_i[2] = 32'h0000_0100;
        a_be_i[2] = 4'b0011; a_wdata_i[2] = 32'hDEAD_BEEF; tcdm_gnt_i[2] = 1'b1;
        #1;
        chk("wr_a_gnt", 64'(a_gnt_o[2]), 64'h1);
        chk("wr_b_gnt", 64'(b_gnt_o[2]), 64'h0);
        chk("wr_wen", 64'(tcdm_wen_o[2]), 64'h0);
        chk("wr_be", 64'(tcdm_be_o[2]), 64'h3);
        chk("wr_add", 64'(tcdm_add_o[2]), 64'h100);
        chk("wr_wdata", 64'(tcdm_wdata_o[2]), 64'hDEAD_BEEF);
        next_cyc();
        clear_inputs();
        tcdm_r_valid_i[2] = 1'b1;
        #1;
        chk("wr_a_rvalid", 64'(a_r_valid_o[2]), 64'h1);
        chk("wr_b_rvalid", 64'(b_r_valid_o[2]), 64'h0);
        next_cyc();
        clear_inputs();
        #1;
        chk("wr_a_rvalid_once", 64'(a_r_valid_o[2]), 64'h0);

        // Lane 1: three A reads with no responses; third stalls until the first response arrives.
        a_req_i[1] = 1'b1; tcdm_gnt_i[1] = 1'b1;
        #1;
        chk("os_gnt0", 64'(a_gnt_o[1]), 64'h1);
        next_cyc();
        #1;
        chk("os_gnt1", 64'(a_gnt_o[1]), 64'h1);
        next_cyc();
        #1;
        chk("os_stall_req", 64'(tcdm_req_o[1]), 64'h0);
        chk("os_stall_gnt", 64'(a_gnt_o[1]), 64'h0);
        chk("os_busy", 64'(busy_o), 64'h1);
        next_cyc();
        tcdm_r_valid_i[1] = 1'b1;
        #1;
        chk("os_resume_req", 64'(tcdm_req_o[1]), 64'h1);
        chk("os_resume_gnt", 64'(a_gnt_o[1]), 64'h1);
        chk("os_rvalid0", 64'(a_r_valid_o[1]), 64'h1);
        next_cyc();
        a_req_i[1] = 1'b0;
        #1;
        chk("os_rvalid1", 64'(a_r_valid_o[1]), 64'h1);
        next_cyc();
        #1;
        chk("os_rvalid2", 64'(a_r_valid_o[1]), 64'h1);
        next_cyc();
        clear_inputs();
        #1;
        chk("os_drained", 64'(busy_o), 64'h0);

        // Lane 3: orphan response raises the sticky error.
        tcdm_r_valid_i[3] = 1'b1;
        #1;
        chk("orph_rvalid", 64'({a_r_valid_o[3], b_r_valid_o[3]}), 64'h0);
        chk("orph_err_same", 64'(err_o), 64'h0);
        next_cyc();
        tcdm_r_valid_i[3] = 1'b0;
        #1;
        chk("orph_err_set", 64'(err_o), 64'h1);
        next_cyc();
        #1;
        chk("orph_err_sticky", 64'(err_o), 64'h1);
        do_reset();

        // All lanes contended, only lanes 0 and 2 granted: prio flips only there.
        a_req_i = 4'b1111; b_req_i = 4'b1111; tcdm_gnt_i = 4'b0101;
        #1;
        chk("pr_req", 64'(tcdm_req_o), 64'hF);
        chk("pr_a_gnt0", 64'(a_gnt_o), 64'h5);
        chk("pr_b_gnt0", 64'(b_gnt_o), 64'h0);
        next_cyc();
        #1;
        chk("pr_a_gnt1", 64'(a_gnt_o), 64'h0);
        chk("pr_b_gnt1", 64'(b_gnt_o), 64'h5);
        next_cyc();
        tcdm_gnt_i = 4'b1010;
        #1;
        chk("pr_a_gnt2", 64'(a_gnt_o), 64'hA);
        chk("pr_b_gnt2", 64'(b_gnt_o), 64'h0);
        next_cyc();
        clear_inputs();
        tcdm_r_valid_i = 4'b1111;
        #1;
        chk("pr_a_rvalid", 64'(a_r_valid_o), 64'hF);
        chk("pr_b_rvalid", 64'(b_r_valid_o), 64'h0);
        next_cyc();
        tcdm_r_valid_i = 4'b0101;
        #1;
        chk("pr_b_rvalid2", 64'(b_r_valid_o), 64'h5);
        chk("pr_a_rvalid2", 64'(a_r_valid_o), 64'h0);
        next_cyc();
        clear_inputs();
        #1;
        chk("pr_drained", 64'(busy_o), 64'h0);
        chk("pr_err", 64'(err_o), 64'h0);
`else
        // Fixed priority: A wins every contended cycle, B gets the first free cycle.
        for (int i = 0; i < 8; i++) begin
            if (i > 0) next_cyc();
            a_req_i[0] = 1'b1; b_req_i[0] = 1'b1; tcdm_gnt_i[0] = 1'b1;
            tcdm_r_valid_i[0] = (i >= 1);
            #1;
            chk("fp_a_gnt", 64'(a_gnt_o[0]), 64'h1);
            chk("fp_b_gnt", 64'(b_gnt_o[0]), 64'h0);
        end
        next_cyc();
        a_req_i[0] = 1'b0;
        #1;
        chk("fp_b_gnt_free", 64'(b_gnt_o[0]), 64'h1);
        chk("fp_a_rvalid", 64'(a_r_valid_o[0]), 64'h1);
        next_cyc();
        b_req_i[0] = 1'b0;
        #1;
        chk("fp_b_rvalid", 64'(b_r_valid_o[0]), 64'h1);
        next_cyc();
        clear_inputs();
        #1;
        chk("fp_drained", 64'(busy_o), 64'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
